// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and header helper for the Ethernet receive path.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0]  ETH_SFD           = 8'hAB;
  localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
  localparam int          ETH_HDR_LEN       = 14;
  localparam logic [47:0] ETH_BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    HUNT,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    DROP
  } rx_state_e;

  // MAC bytes go on the wire most-significant byte first.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] idx);
    logic [47:0] w_shifted;
    w_shifted = mac << (8 * idx);
    return w_shifted[47:40];
  endfunction

endpackage

// File: rtl/rx_word_packer.sv
// Packs payload bytes into words and holds one output word under a valid/ready handshake.
module rx_word_packer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_start,
  input  logic                    i_push,
  input  logic                    i_flush,
  input  logic [7:0]              i_byte,
  input  logic                    i_data_ready,
  output logic                    o_pack_empty,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [DATA_WIDTH/8-1:0] o_keep,
  output logic                    o_valid,
  output logic                    o_sof,
  output logic                    o_eof
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(BYTES + 1);

  logic [DATA_WIDTH-1:0] r_pack;
  logic [CW-1:0]         r_pack_cnt;
  logic                  r_sof_pend;
  logic [DATA_WIDTH-1:0] r_data;
  logic [BYTES-1:0]      r_keep;
  logic                  r_valid, r_sof, r_eof;
  logic                  w_full, w_load;
  logic [BYTES-1:0]      w_keep_part;

  assign w_full       = (r_pack_cnt == CW'(BYTES));
  assign w_load       = (i_push && w_full) || i_flush;
  assign o_pack_empty = (r_pack_cnt == '0);

  always_comb begin
    for (int i = 0; i < BYTES; i++) w_keep_part[i] = (CW'(i) < r_pack_cnt);
  end

  // NOTE: the pack register is reset and cleared between frames so lanes past
  // the last byte of a short word read as zero rather than stale payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pack     <= '0;
      r_pack_cnt <= '0;
      r_sof_pend <= 1'b0;
      r_data     <= '0;
      r_keep     <= '0;
      r_valid    <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
    end else begin
      // Loads only happen on an accepted byte, which implies the slot is free.
      if (w_load) begin
        r_data     <= r_pack;
        r_keep     <= i_flush ? w_keep_part : '1;
        r_sof      <= r_sof_pend;
        r_eof      <= i_flush;
        r_valid    <= 1'b1;
        r_sof_pend <= 1'b0;
      end else if (i_data_ready) begin
        r_valid <= 1'b0;
      end

      if (i_start) begin
        r_pack     <= '0;
        r_pack_cnt <= '0;
        r_sof_pend <= 1'b1;
      end else if (i_flush) begin
        r_pack     <= '0;
        r_pack_cnt <= '0;
      end else if (i_push) begin
        if (w_full) begin
          r_pack     <= DATA_WIDTH'(i_byte);
          r_pack_cnt <= CW'(1);
        end else begin
          r_pack[8*r_pack_cnt +: 8] <= i_byte;
          r_pack_cnt                <= r_pack_cnt + CW'(1);
        end
      end
    end
  end

  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_valid = r_valid;
  assign o_sof   = r_sof;
  assign o_eof   = r_eof;

endmodule

// File: rtl/ethernet_deframer.sv
// Ethernet receive deframer: preamble/SFD hunt, header filter, payload repacking, frame counters.
module ethernet_deframer
  import eth_pkg::*;
#(
  parameter int          DATA_WIDTH   = 64,
  parameter logic [47:0] DEST_MAC     = 48'hAABBCCDDEEFF,
  parameter int          PREAMBLE_MIN = 7
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              eth_rx_data,
  input  logic                    eth_rx_valid,
  input  logic                    eth_rx_last,
  output logic                    eth_rx_ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [DATA_WIDTH/8-1:0] data_keep,
  output logic                    data_valid,
  output logic                    data_sof,
  output logic                    data_eof,
  input  logic                    data_ready,
  output logic [31:0]             frames_received,
  output logic [31:0]             frames_dropped,
  output logic [31:0]             bytes_received
);

  rx_state_e   r_state, w_state_next;
  logic [3:0]  r_pre_cnt, r_hdr_idx;
  logic        r_dest_mis, r_bcast_mis, r_type_mis;
  logic        w_dest_mis, w_bcast_mis, w_type_mis, w_hdr_bad;
  logic [15:0] r_pay_cnt;
  logic [31:0] r_frames_received, r_frames_dropped, r_bytes_received;
  logic        w_accept, w_start, w_push, w_flush, w_drop, w_pack_empty;

  assign eth_rx_ready = !data_valid || data_ready;
  assign w_accept     = eth_rx_valid && eth_rx_ready;

  // Sticky mismatch flags including the byte currently on the bus.
  assign w_dest_mis  = r_dest_mis  || (r_hdr_idx < 4'd6 && eth_rx_data != mac_byte(DEST_MAC, r_hdr_idx));
  assign w_bcast_mis = r_bcast_mis || (r_hdr_idx < 4'd6 && eth_rx_data != mac_byte(ETH_BCAST_MAC, r_hdr_idx));
  assign w_type_mis  = r_type_mis
                    || (r_hdr_idx == 4'd12 && eth_rx_data != ETHERTYPE_IPV4[15:8])
                    || (r_hdr_idx == 4'd13 && eth_rx_data != ETHERTYPE_IPV4[7:0]);
  assign w_hdr_bad   = (w_dest_mis && w_bcast_mis) || w_type_mis;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= HUNT;
    else          r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    w_drop       = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        HUNT: begin
          if (!eth_rx_last && eth_rx_data == ETH_PREAMBLE_BYTE) w_state_next = PREAMBLE;
        end
        PREAMBLE: begin
          if (eth_rx_last) begin
            w_drop       = 1'b1;
            w_state_next = HUNT;
          end else if (eth_rx_data == ETH_SFD && int'(r_pre_cnt) >= PREAMBLE_MIN) begin
            w_start      = 1'b1;
            w_state_next = HEADER;
          end else if (eth_rx_data != ETH_PREAMBLE_BYTE) begin
            w_state_next = HUNT;
          end
        end
        HEADER: begin
          if (eth_rx_last) begin
            w_drop       = 1'b1;
            w_state_next = HUNT;
          end else if (r_hdr_idx == 4'(ETH_HDR_LEN - 1)) begin
            w_state_next = w_hdr_bad ? DROP : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (eth_rx_last) begin
            w_flush      = !w_pack_empty;
            w_drop       = w_pack_empty;
            w_state_next = HUNT;
          end else begin
            w_push = 1'b1;
          end
        end
        DROP: begin
          if (eth_rx_last) begin
            w_drop       = 1'b1;
            w_state_next = HUNT;
          end
        end
        default: w_state_next = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt         <= '0;
      r_hdr_idx         <= '0;
      r_dest_mis        <= 1'b0;
      r_bcast_mis       <= 1'b0;
      r_type_mis        <= 1'b0;
      r_pay_cnt         <= '0;
      r_frames_received <= '0;
      r_frames_dropped  <= '0;
      r_bytes_received  <= '0;
    end else begin
      if (w_accept && r_state == HUNT) begin
        r_pre_cnt <= 4'd1;
      end else if (w_accept && r_state == PREAMBLE && eth_rx_data == ETH_PREAMBLE_BYTE
                   && r_pre_cnt != 4'hF) begin
        r_pre_cnt <= r_pre_cnt + 4'd1;
      end

      if (w_start) begin
        r_hdr_idx   <= '0;
        r_dest_mis  <= 1'b0;
        r_bcast_mis <= 1'b0;
        r_type_mis  <= 1'b0;
        r_pay_cnt   <= '0;
      end else if (w_accept && r_state == HEADER) begin
        r_hdr_idx   <= r_hdr_idx + 4'd1;
        r_dest_mis  <= w_dest_mis;
        r_bcast_mis <= w_bcast_mis;
        r_type_mis  <= w_type_mis;
      end

      if (w_push && r_pay_cnt != 16'hFFFF) r_pay_cnt <= r_pay_cnt + 16'd1;

      if (w_flush) begin
        r_frames_received <= r_frames_received + 32'd1;
        r_bytes_received  <= r_bytes_received + 32'(r_pay_cnt);
      end
      if (w_drop) r_frames_dropped <= r_frames_dropped + 32'd1;
    end
  end

  rx_word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (w_start),
    .i_push       (w_push),
    .i_flush      (w_flush),
    .i_byte       (eth_rx_data),
    .i_data_ready (data_ready),
    .o_pack_empty (w_pack_empty),
    .o_data       (data_out),
    .o_keep       (data_keep),
    .o_valid      (data_valid),
    .o_sof        (data_sof),
    .o_eof        (data_eof)
  );

  assign frames_received = r_frames_received;
  assign frames_dropped  = r_frames_dropped;
  assign bytes_received  = r_bytes_received;

endmodule

// File: tb/tb_ethernet_deframer.sv
// Self-checking bench for ethernet_deframer: frame table, scoreboard, backpressure and reset cases.
module tb_ethernet_deframer;

  localparam int          DW     = 64;
  localparam int          BYTES  = DW / 8;
  localparam logic [47:0] MY_MAC = 48'hAABBCCDDEEFF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    eth_rx_data;
  logic          eth_rx_valid, eth_rx_last, eth_rx_ready;
  logic [DW-1:0] data_out;
  logic [BYTES-1:0] data_keep;
  logic          data_valid, data_sof, data_eof, data_ready;
  logic [31:0]   frames_received, frames_dropped, bytes_received;

  ethernet_deframer #(.DATA_WIDTH(DW), .DEST_MAC(MY_MAC), .PREAMBLE_MIN(7)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .eth_rx_data     (eth_rx_data),
    .eth_rx_valid    (eth_rx_valid),
    .eth_rx_last     (eth_rx_last),
    .eth_rx_ready    (eth_rx_ready),
    .data_out        (data_out),
    .data_keep       (data_keep),
    .data_valid      (data_valid),
    .data_sof        (data_sof),
    .data_eof        (data_eof),
    .data_ready      (data_ready),
    .frames_received (frames_received),
    .frames_dropped  (frames_dropped),
    .bytes_received  (bytes_received)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          pre_len;
    logic [47:0] dmac;
    logic [15:0] etype;
    int          pay_len;
    int          outcome;  // 0 delivered, 1 dropped, 2 never framed
  } vec_t;

  typedef struct {
    logic [DW-1:0]    data;
    logic [BYTES-1:0] keep;
    logic             sof;
    logic             eof;
  } word_t;

  word_t exp_q[$];
  word_t got_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    m_rx = 0, m_drop = 0, m_bytes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (reset_n === 1'b1 && data_valid === 1'b1 && data_ready === 1'b1)
      got_q.push_back('{data_out, data_keep, data_sof, data_eof});
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    logic acc;
    int   guard;
    guard = 0;
    do begin
      @(negedge clk);
      eth_rx_data  = b;
      eth_rx_valid = 1'b1;
      eth_rx_last  = last;
      #1 acc = eth_rx_ready;
      @(posedge clk);
      guard++;
    end while (!acc && guard < 500);
    if (!acc) check("send_timeout", 64'(guard), 64'd0);
  endtask

  task automatic push_expected(input int len);
    word_t w;
    for (int s = 0; s < len; s += BYTES) begin
      w.data = '0;
      w.keep = '0;
      for (int k = 0; k < BYTES && s + k < len; k++) begin
        w.data[8*k +: 8] = 8'(s + k);
        w.keep[k]        = 1'b1;
      end
      w.sof = (s == 0);
      w.eof = (s + BYTES >= len);
      exp_q.push_back(w);
    end
  endtask

  task automatic send_frame(input vec_t v);
    logic [47:0] src;
    src = 48'h112233445566;
    if (v.outcome == 0) begin
      push_expected(v.pay_len);
      m_rx++;
      m_bytes += v.pay_len;
    end else if (v.outcome == 1) begin
      m_drop++;
    end
    for (int i = 0; i < v.pre_len; i++) send_byte(8'hAA, 1'b0);
    send_byte(8'hAB, 1'b0);
    for (int k = 0; k < 6; k++) send_byte(v.dmac[8*(5-k) +: 8], 1'b0);
    for (int k = 0; k < 6; k++) send_byte(src[8*(5-k) +: 8], 1'b0);
    send_byte(v.etype[15:8], 1'b0);
    send_byte(v.etype[7:0], 1'b0);
    for (int i = 0; i < v.pay_len; i++) send_byte(8'(i), 1'b0);
    send_byte(8'h00, 1'b1);
    @(negedge clk);
    eth_rx_valid = 1'b0;
    eth_rx_last  = 1'b0;
  endtask

  task automatic drain_and_compare(input string name);
    int    cyc;
    word_t e, g;
    cyc = 0;
    while ((got_q.size() < exp_q.size() || data_valid) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check({name, "_word_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({name, "_data"}, g.data, e.data);
      check({name, "_keep"}, 64'(g.keep), 64'(e.keep));
      check({name, "_sof_eof"}, {62'd0, g.sof, g.eof}, {62'd0, e.sof, e.eof});
    end
    exp_q.delete();
    got_q.delete();
    check({name, "_frames_received"}, 64'(frames_received), 64'(m_rx));
    check({name, "_frames_dropped"}, 64'(frames_dropped), 64'(m_drop));
    check({name, "_bytes_received"}, 64'(bytes_received), 64'(m_bytes));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[11];
    vec_t        v;
    logic [63:0] snap_data;
    logic [7:0]  snap_keep;
    int          c;

    vecs[0]  = '{"basic16",       7,  MY_MAC,          16'h0800, 16, 0};
    vecs[1]  = '{"short3",        7,  MY_MAC,          16'h0800, 3,  0};
    vecs[2]  = '{"bad_dest",      7,  48'h010203040506, 16'h0800, 16, 1};
    vecs[3]  = '{"bad_type",      7,  MY_MAC,          16'h86DD, 16, 1};
    vecs[4]  = '{"after_drop",    7,  MY_MAC,          16'h0800, 16, 0};
    vecs[5]  = '{"bcast_longpre", 20, 48'hFFFFFFFFFFFF, 16'h0800, 5,  0};
    vecs[6]  = '{"one_word",      7,  MY_MAC,          16'h0800, 8,  0};
    vecs[7]  = '{"empty",         7,  MY_MAC,          16'h0800, 0,  1};
    vecs[8]  = '{"nine",          8,  MY_MAC,          16'h0800, 9,  0};
    vecs[9]  = '{"dest_lastbyte", 7,  48'hAABBCCDDEEFE, 16'h0800, 4,  1};
    vecs[10] = '{"short_pre",     6,  MY_MAC,          16'h0800, 4,  2};

    reset_n      = 1'b0;
    eth_rx_data  = '0;
    eth_rx_valid = 1'b0;
    eth_rx_last  = 1'b0;
    data_ready   = 1'b1;
    #1;
    check("reset_data_valid", 64'(data_valid), 64'd0);
    check("reset_data_out", data_out, 64'd0);
    check("reset_rx_ready", 64'(eth_rx_ready), 64'd1);
    check("reset_counters", {32'(frames_received | frames_dropped), bytes_received}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i]);
      drain_and_compare(vecs[i].name);
    end

    // 5 preamble bytes then SFD: never framed, trailing last must be ignored.
    for (int i = 0; i < 5; i++) send_byte(8'hAA, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    @(negedge clk);
    eth_rx_valid = 1'b0;
    eth_rx_last  = 1'b0;
    drain_and_compare("short_preamble");

    // Runt: last on header byte 6.
    for (int i = 0; i < 7; i++) send_byte(8'hAA, 1'b0);
    send_byte(8'hAB, 1'b0);
    for (int k = 0; k < 6; k++) send_byte(MY_MAC[8*(5-k) +: 8], 1'b0);
    send_byte(8'h11, 1'b1);
    @(negedge clk);
    eth_rx_valid = 1'b0;
    eth_rx_last  = 1'b0;
    m_drop++;
    drain_and_compare("runt_header");

    // Backpressure: hold data_ready low 20 cycles once the first word is out.
    v = '{"stall", 7, MY_MAC, 16'h0800, 40, 0};
    fork
      send_frame(v);
      begin
        c = 0;
        while (!data_valid && c < 300) begin
          @(negedge clk);
          c++;
        end
        check("stall_saw_valid", 64'(data_valid), 64'd1);
        data_ready = 1'b0;
        #1;
        check("stall_rx_ready_low", 64'(eth_rx_ready), 64'd0);
        snap_data = data_out;
        snap_keep = data_keep;
        repeat (19) @(negedge clk);
        #1;
        check("stall_data_held", data_out, snap_data);
        check("stall_keep_held", 64'(data_keep), 64'(snap_keep));
        check("stall_rx_ready_still_low", 64'(eth_rx_ready), 64'd0);
        @(negedge clk);
        data_ready = 1'b1;
      end
    join
    drain_and_compare("stall");

    // Asynchronous reset while a word is held at the output mid-payload.
    data_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(8'hAA, 1'b0);
    send_byte(8'hAB, 1'b0);
    for (int k = 0; k < 6; k++) send_byte(MY_MAC[8*(5-k) +: 8], 1'b0);
    for (int k = 0; k < 6; k++) send_byte(8'h33, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b0);
    @(negedge clk);
    eth_rx_valid = 1'b0;
    #1;
    check("prereset_word_held", 64'(data_valid), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(data_valid), 64'd0);
    check("async_reset_data", data_out, 64'd0);
    check("async_reset_keep_sof_eof", {54'd0, data_keep, data_sof, data_eof}, 64'd0);
    check("async_reset_rx_ready", 64'(eth_rx_ready), 64'd1);
    check("async_reset_frames_received", 64'(frames_received), 64'd0);
    check("async_reset_bytes_received", 64'(bytes_received), 64'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    data_ready = 1'b1;
    m_rx    = 0;
    m_drop  = 0;
    m_bytes = 0;
    v = '{"post_reset", 7, MY_MAC, 16'h0800, 16, 0};
    send_frame(v);
    drain_and_compare("post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
